// File: rtl/writeback_arbiter_pkg.sv
// Shared constants for the writeback arbiter slice.
//   c_max_wb_pipes   largest supported number of completing execute pipes
//   c_reg_addr_bits  architectural register index width
//   c_data_bits      result data width
//   ptr_bits()       width of a round-robin pointer over n requesters
//
// The completion entry type depends on the sequence-number width, so each
// instantiating module declares its own wb_entry_t from this field list:
//   {val, seq_num[p_seq_num_bits], waddr[c_reg_addr_bits], wdata[c_data_bits], wen}
package writeback_arbiter_pkg;

    localparam int c_max_wb_pipes  = 8;
    localparam int c_reg_addr_bits = 5;
    localparam int c_data_bits     = 32;

    // A single requester still gets a 1-bit pointer so every vector is legal.
    function automatic int ptr_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/writeback_arbiter_rr.sv
// Round-robin arbiter with a registered priority pointer.
//   clk        clock
//   rst        asynchronous active-high reset, forces ptr to 0
//   req        request vector, one bit per requester
//   advance    move ptr to one past the current grant (asserted on a transfer)
//   grant      one-hot grant, zero when no request
//   grant_idx  binary index of the granted requester, 0 when no request
//
// Priority starts at ptr and wraps modulo p_width.
module writeback_arbiter_rr
    import writeback_arbiter_pkg::*;
#(
    parameter int p_width = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [p_width-1:0]             req,
    input  logic                           advance,
    output logic [p_width-1:0]             grant,
    output logic [ptr_bits(p_width)-1:0]   grant_idx
);

    localparam int PW = ptr_bits(p_width);

    logic [PW-1:0]          ptr;
    logic [PW-1:0]          ptr_next;
    logic [2*p_width-1:0]   req_rot_full;
    logic [p_width-1:0]     req_rot;
    logic [PW-1:0]          offset;
    logic [PW:0]            idx_sum;
    logic                   found;

    // Rotate the request vector so bit 0 is the requester at ptr; the first
    // set bit of the rotated vector is the winner's distance from ptr.
    always_comb begin
        req_rot_full = {req, req} >> ptr;
        req_rot      = req_rot_full[p_width-1:0];

        found  = 1'b0;
        offset = '0;
        for (int i = 0; i < p_width; i++) begin
            if (!found && req_rot[i]) begin
                found  = 1'b1;
                offset = PW'(i);
            end
        end

        idx_sum = {1'b0, ptr} + {1'b0, offset};
        if (idx_sum >= (PW+1)'(p_width)) begin
            idx_sum = idx_sum - (PW+1)'(p_width);
        end

        grant_idx = found ? idx_sum[PW-1:0] : '0;
        grant     = found ? (p_width'(1) << grant_idx) : '0;
    end

    always_comb begin
        ptr_next = ptr;
        if (advance) begin
            if (grant_idx == PW'(p_width - 1)) begin
                ptr_next = '0;
            end else begin
                ptr_next = grant_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: shares the single completion path among p_num_pipes
// execute pipes. One pipe is granted per cycle in round-robin order and its
// result is registered onto the completion outputs on the following cycle.
//   clk               clock
//   rst               asynchronous active-high reset
//   W_val[k]          pipe k holds a completed result
//   W_rdy[k]          grant to pipe k (combinational from W_val and ptr)
//   W_seq_num         packed per-pipe sequence numbers, pipe k at [k*p_seq_num_bits +: p_seq_num_bits]
//   W_waddr           packed per-pipe destination registers, pipe k at [k*5 +: 5]
//   W_wdata           packed per-pipe result data, pipe k at [k*32 +: 32]
//   W_wen[k]          pipe k result writes the register file
//   complete_*        registered completion notification {val, seq_num, waddr, wdata, wen}
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int p_num_pipes    = 1,
    parameter int p_seq_num_bits = 5
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [p_num_pipes-1:0]                W_val,
    output logic [p_num_pipes-1:0]                W_rdy,
    input  logic [p_num_pipes*p_seq_num_bits-1:0] W_seq_num,
    input  logic [p_num_pipes*c_reg_addr_bits-1:0] W_waddr,
    input  logic [p_num_pipes*c_data_bits-1:0]    W_wdata,
    input  logic [p_num_pipes-1:0]                W_wen,
    output logic                                  complete_val,
    output logic [p_seq_num_bits-1:0]             complete_seq_num,
    output logic [c_reg_addr_bits-1:0]            complete_waddr,
    output logic [c_data_bits-1:0]                complete_wdata,
    output logic                                  complete_wen
);

    localparam int PW = ptr_bits(p_num_pipes);

    typedef struct packed {
        logic                       val;
        logic [p_seq_num_bits-1:0]  seq_num;
        logic [c_reg_addr_bits-1:0] waddr;
        logic [c_data_bits-1:0]     wdata;
        logic                       wen;
    } wb_entry_t;

    logic [p_num_pipes-1:0] req;
    logic [p_num_pipes-1:0] grant;
    logic [PW-1:0]          grant_idx;
    logic                   transfer;
    wb_entry_t              sel;
    wb_entry_t              complete_q;

    // Holding requests off during reset keeps W_rdy low for the whole
    // reset window, so no pipe believes it transferred into a register
    // that is being cleared.
    assign req      = W_val & {p_num_pipes{~rst}};
    assign W_rdy    = grant;
    assign transfer = |grant;

    writeback_arbiter_rr #(
        .p_width (p_num_pipes)
    ) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .advance   (transfer),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // AND-OR mux over the one-hot grant; an idle cycle selects all zeros,
    // which is exactly what the output register loads when nothing transfers.
    always_comb begin
        sel = '0;
        for (int k = 0; k < p_num_pipes; k++) begin
            if (grant[k]) begin
                sel.val     = 1'b1;
                sel.seq_num = W_seq_num[k*p_seq_num_bits +: p_seq_num_bits];
                sel.waddr   = W_waddr[k*c_reg_addr_bits +: c_reg_addr_bits];
                sel.wdata   = W_wdata[k*c_data_bits +: c_data_bits];
                sel.wen     = W_wen[k];
            end
        end
    end

    // Results with wen=0 still produce a completion so downstream retires
    // their sequence number. There is no backpressure on this register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            complete_q <= '0;
        end else begin
            complete_q <= sel;
        end
    end

    assign complete_val     = complete_q.val;
    assign complete_seq_num = complete_q.seq_num;
    assign complete_waddr   = complete_q.waddr;
    assign complete_wdata   = complete_q.wdata;
    assign complete_wen     = complete_q.wen;

endmodule

// File: tb/tb_writeback_arbiter.sv
module tb_writeback_arbiter;

    logic clk;
    logic rst;

    // four-pipe instance
    logic [3:0]   val4;
    logic [3:0]   rdy4;
    logic [19:0]  seq4;
    logic [19:0]  waddr4;
    logic [127:0] wdata4;
    logic [3:0]   wen4;
    logic         c4_val;
    logic [4:0]   c4_seq;
    logic [4:0]   c4_waddr;
    logic [31:0]  c4_wdata;
    logic         c4_wen;

    // single-pipe instance
    logic [0:0]   val1;
    logic [0:0]   rdy1;
    logic [4:0]   seq1;
    logic [4:0]   waddr1;
    logic [31:0]  wdata1;
    logic [0:0]   wen1;
    logic         c1_val;
    logic [4:0]   c1_seq;
    logic [4:0]   c1_waddr;
    logic [31:0]  c1_wdata;
    logic         c1_wen;

    int n_checks;
    int n_errors;

    writeback_arbiter #(.p_num_pipes(4), .p_seq_num_bits(5)) u_dut4 (
        .clk              (clk),
        .rst              (rst),
        .W_val            (val4),
        .W_rdy            (rdy4),
        .W_seq_num        (seq4),
        .W_waddr          (waddr4),
        .W_wdata          (wdata4),
        .W_wen            (wen4),
        .complete_val     (c4_val),
        .complete_seq_num (c4_seq),
        .complete_waddr   (c4_waddr),
        .complete_wdata   (c4_wdata),
        .complete_wen     (c4_wen)
    );

    writeback_arbiter #(.p_num_pipes(1), .p_seq_num_bits(5)) u_dut1 (
        .clk              (clk),
        .rst              (rst),
        .W_val            (val1),
        .W_rdy            (rdy1),
        .W_seq_num        (seq1),
        .W_waddr          (waddr1),
        .W_wdata          (wdata1),
        .W_wen            (wen1),
        .complete_val     (c1_val),
        .complete_seq_num (c1_seq),
        .complete_waddr   (c1_waddr),
        .complete_wdata   (c1_wdata),
        .complete_wen     (c1_wen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_pipe(input int k, input logic v, input logic [4:0] s,
                            input logic [4:0] a, input logic [31:0] d, input logic w);
        val4[k]           = v;
        seq4[k*5 +: 5]    = s;
        waddr4[k*5 +: 5]  = a;
        wdata4[k*32 +: 32] = d;
        wen4[k]           = w;
    endtask

    task automatic check_c4(input string tag, input logic v, input logic [4:0] s,
                            input logic [4:0] a, input logic [31:0] d, input logic w);
        check({tag, ".val"},   64'(c4_val),   64'(v));
        check({tag, ".seq"},   64'(c4_seq),   64'(s));
        check({tag, ".waddr"}, 64'(c4_waddr), 64'(a));
        check({tag, ".wdata"}, 64'(c4_wdata), 64'(d));
        check({tag, ".wen"},   64'(c4_wen),   64'(w));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [0:0] pat1 [4];
    logic       prev1;

    initial begin
        n_checks = 0;
        n_errors = 0;
        val4 = '0; seq4 = '0; waddr4 = '0; wdata4 = '0; wen4 = '0;
        val1 = '0; seq1 = '0; waddr1 = '0; wdata1 = '0; wen1 = '0;

        // reset: grants suppressed even with requests present
        rst = 1'b1;
        val4 = 4'hF;
        val1 = 1'b1;
        #12;
        check("rst_rdy4", 64'(rdy4), 64'h0);
        check("rst_rdy1", 64'(rdy1), 64'h0);
        check_c4("rst_c4", 1'b0, 5'd0, 5'd0, 32'd0, 1'b0);
        check("rst_c1_val", 64'(c1_val), 64'h0);
        val4 = '0;
        val1 = '0;
        @(negedge clk);
        rst = 1'b0;
        tick();

        // single requester: pipe 2
        set_pipe(2, 1'b1, 5'd3, 5'd5, 32'hDEADBEEF, 1'b1);
        #1;
        check("single_rdy", 64'(rdy4), 64'h4);
        tick();
        set_pipe(2, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0);
        check_c4("single_c4", 1'b1, 5'd3, 5'd5, 32'hDEADBEEF, 1'b1);

        // pointer wrap: ptr=3, pipes 0 and 3 valid
        set_pipe(0, 1'b1, 5'd10, 5'd1, 32'h0000_1111, 1'b1);
        set_pipe(3, 1'b1, 5'd13, 5'd4, 32'h0000_3333, 1'b1);
        #1;
        check("wrap_rdy_a", 64'(rdy4), 64'h8);
        tick();
        set_pipe(3, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0);
        check_c4("wrap_c4_a", 1'b1, 5'd13, 5'd4, 32'h0000_3333, 1'b1);
        #1;
        check("wrap_rdy_b", 64'(rdy4), 64'h1);
        tick();
        set_pipe(0, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0);
        check_c4("wrap_c4_b", 1'b1, 5'd10, 5'd1, 32'h0000_1111, 1'b1);

        // wen=0 result: ptr=1, pipe 1 (wen 0) and pipe 2 valid
        set_pipe(1, 1'b1, 5'd7, 5'd9, 32'hCAFE_0001, 1'b0);
        set_pipe(2, 1'b1, 5'd8, 5'd6, 32'hCAFE_0002, 1'b1);
        #1;
        check("wen0_rdy", 64'(rdy4), 64'h2);
        tick();
        set_pipe(1, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0);
        check_c4("wen0_c4", 1'b1, 5'd7, 5'd9, 32'hCAFE_0001, 1'b0);
        #1;
        check("wen0_next_rdy", 64'(rdy4), 64'h4);
        tick();
        set_pipe(2, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0);
        check_c4("wen0_next_c4", 1'b1, 5'd8, 5'd6, 32'hCAFE_0002, 1'b1);
        tick();
        check_c4("idle_c4", 1'b0, 5'd0, 5'd0, 32'd0, 1'b0);

        // all requesting from reset: order 0,1,2,3,0
        rst = 1'b1;
        #2;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_pipe(k, 1'b1, 5'(10 + k), 5'(20 + k), 32'hB000_0000 + 32'(k), 1'b1);
        end
        #1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("all_rdy_%0d", i), 64'(rdy4), 64'(4'b0001 << (i % 4)));
            tick();
            check_c4($sformatf("all_c4_%0d", i), 1'b1, 5'(10 + (i % 4)), 5'(20 + (i % 4)),
                     32'hB000_0000 + 32'(i % 4), 1'b1);
        end
        val4 = '0;
        tick();

        // reset mid-operation; ptr=1 here
        set_pipe(1, 1'b1, 5'd21, 5'd11, 32'h1111_0000, 1'b1);
        set_pipe(2, 1'b1, 5'd22, 5'd12, 32'h2222_0000, 1'b1);
        #1;
        check("mid_rdy_a", 64'(rdy4), 64'h2);
        tick();
        set_pipe(1, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0);
        check("mid_c4_val_pre", 64'(c4_val), 64'h1);
        set_pipe(0, 1'b1, 5'd20, 5'd10, 32'h0000_0000, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_c4("mid_rst_c4", 1'b0, 5'd0, 5'd0, 32'd0, 1'b0);
        check("mid_rst_rdy", 64'(rdy4), 64'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("mid_after_rdy", 64'(rdy4), 64'h1);
        tick();
        set_pipe(0, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0);
        check_c4("mid_after_c4", 1'b1, 5'd20, 5'd10, 32'h0000_0000, 1'b0);
        #1;
        check("mid_after_rdy2", 64'(rdy4), 64'h4);
        tick();
        set_pipe(2, 1'b0, 5'd0, 5'd0, 32'd0, 1'b0);
        check_c4("mid_after_c4_2", 1'b1, 5'd22, 5'd12, 32'h2222_0000, 1'b1);

        // single pipe: W_val 1,1,0,1
        pat1[0] = 1'b1; pat1[1] = 1'b1; pat1[2] = 1'b0; pat1[3] = 1'b1;
        prev1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            val1   = pat1[i];
            seq1   = 5'(i + 1);
            waddr1 = 5'(i + 2);
            wdata1 = 32'h5000_0000 + 32'(i);
            wen1   = 1'b1;
            #1;
            check($sformatf("p1_rdy_%0d", i), 64'(rdy1), 64'(pat1[i]));
            tick();
            check($sformatf("p1_val_%0d", i), 64'(c1_val), 64'(pat1[i]));
            check($sformatf("p1_seq_%0d", i), 64'(c1_seq), pat1[i] ? 64'(i + 1) : 64'h0);
            check($sformatf("p1_wdata_%0d", i), 64'(c1_wdata),
                  pat1[i] ? 64'(32'h5000_0000 + 32'(i)) : 64'h0);
            prev1 = pat1[i];
        end
        val1 = '0;
        tick();
        check("p1_val_tail", 64'(c1_val), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Shares the single completion/writeback path (the `CompleteNotif` publisher side that feeds the register file write port and pending-bit clear) among `p_num_pipes` execute pipes. Each cycle it grants at most one completing pipe using round-robin priority and registers the granted result onto the completion notification one cycle later. It sits between the execute pipes' writeback outputs and every `CompleteNotif.sub` consumer, including the decode-issue unit.

## Interface
- `p_num_pipes`, default 1: number of completing execute pipes, legal range 1..8.
- `p_seq_num_bits`, default 5: width of the in-flight instruction sequence number.
- `clk` in, 1: clock. All state updates on the rising edge.
- `rst` in, 1: reset. Asynchronous, active-high.
- `W_val[p_num_pipes]` in, 1 each: pipe k holds a completed result.
- `W_rdy[p_num_pipes]` out, 1 each: grant to pipe k. Combinational.
- `W_seq_num[p_num_pipes]` in, `p_seq_num_bits` each: sequence number of the result.
- `W_waddr[p_num_pipes]` in, 5 each: destination architectural register.
- `W_wdata[p_num_pipes]` in, 32 each: result data.
- `W_wen[p_num_pipes]` in, 1 each: result writes the register file.
- `complete.val` out, 1: registered completion valid.
- `complete.seq_num` out, `p_seq_num_bits`: registered sequence number.
- `complete.waddr` out, 5: registered destination register.
- `complete.wdata` out, 32: registered write data.
- `complete.wen` out, 1: registered write enable.

## Operation
- **State:**
  - Round-robin pointer `ptr`, width max(1, clog2(`p_num_pipes`)).
  - One output register holding val, seq_num, waddr, wdata and wen.
- **Grant selection:** grant the first index g with `W_val[g]=1`, scanning `ptr`, `ptr+1`, … modulo `p_num_pipes`.
  - `W_rdy[g]=1` for the granted index only. All other `W_rdy` are 0.
  - No valid input means no grant.
- **Transfer:** occurs for pipe k when `W_val[k] & W_rdy[k]`. At most one transfer per cycle.
- **Pointer update:**
  - On a transfer at g: `ptr <= (g+1) mod p_num_pipes`. Wrap from `p_num_pipes-1` to 0.
  - No transfer: `ptr` holds.
- **Output register:**
  - On a transfer: `complete.val <= 1`, and the other fields take the granted pipe's fields.
  - No transfer: `complete.val <= 0`, and the data fields take 0.
- **Write-enable-0 results:** a result with `W_wen=0` still consumes a grant and still emits a completion with `wen=0`, so downstream consumers retire its seq_num.
- **No backpressure on completion:** a granted result is always emitted on the following cycle.
- **Single pipe (`p_num_pipes=1`):** `W_rdy[0] = W_val[0]`. `ptr` is constant 0.
- **Pipe-side handshake rules:**
  - Once `W_val[k]` is asserted, pipe k holds it and its fields stable until it transfers.
  - Pipes must not make `W_val` depend combinationally on `W_rdy`.
  - `W_rdy` depends combinationally on `W_val` and `ptr` only.
- **Reset:**
  - Asserting `rst` immediately forces `ptr=0`, `complete.val=0` and all completion fields to 0.
  - A completion in flight in the output register is discarded. Upstream flush is owned by the pipeline reset.
  - While `rst` is high, all `W_rdy` are 0.

## Timing
- **Reset values:** `complete.val=0`, `complete.seq_num=0`, `complete.waddr=0`, `complete.wdata=0`, `complete.wen=0`, `W_rdy=0`.
- **Latency:** a transfer in cycle N appears on `complete.*` in cycle N+1 for exactly one cycle.
- **Throughput:** one completion per cycle, sustained.
- **Fairness:** with all pipes continuously valid, each pipe is granted exactly once every `p_num_pipes` cycles.
- **Worst-case wait:** a valid pipe waits at most `p_num_pipes-1` cycles for a grant.
- **Simultaneous requests:** the requester nearest `ptr` (inclusive, wrapping) wins. Losers keep `W_val` high and are granted later.

## Structure
- **Shared package** (in `defs/`):
  - `wb_entry_t` packed struct {val, seq_num, waddr, wdata, wen}, parameterised by `p_seq_num_bits` through its instantiating module.
  - `c_max_wb_pipes = 8`.
- **Sub-module `RoundRobinArbiter`** (parameter `p_width`):
  - Ports: req vector, grant vector (one-hot), grant index, and an `advance` input that updates the internal pointer.
  - Owns `ptr` and its async reset.
  - `writeback_arbiter` adds the data mux and the output register around it.

## Test plan
- **Single requester:** `p_num_pipes=4`, only pipe 2 valid with seq 3, waddr 5, wdata 0xDEADBEEF, wen 1 → `W_rdy[2]=1` that cycle; next cycle `complete` = {1, 3, 5, 0xDEADBEEF, 1}; `ptr=3`.
- **All requesting from reset:** all four pipes valid continuously → grants in order 0,1,2,3,0; `complete.val` high every cycle from cycle 1.
- **Pointer wrap:** `ptr=3`, pipes 0 and 3 valid → pipe 3 granted first, then pipe 0; `ptr` ends at 1.
- **Write-enable-0 result:** pipe 1 valid with wen 0, seq 7 → completion emitted with `wen=0`, seq 7; only one grant consumed.
- **Reset mid-operation:** assert `rst` asynchronously while `complete.val=1` and pipe 2 is waiting → `complete.val` drops to 0 before the next edge; after release, the first grant goes to the lowest valid index from `ptr=0`.
- **Single pipe:** `p_num_pipes=1` with `W_val` toggling 1,1,0,1 → `W_rdy` follows `W_val`; `complete.val` is 1,1,0,1 delayed by one cycle.
